mmm_result_collector: RTL and testbench

- Receiving end of the final PE's word-serial sum stream in the scalable radix-4 Montgomery multiplier.
- Captures N = K/W result words, least significant word (LSW) first, and runs the final conditional subtraction (S - M) word-serially as words arrive.
- Buffers the words, selects S or S-M once the last word is in, and drains the result LSW-first over a valid/ready interface to the host/next stage.

---
 rtl/mmm_pkg.sv | 27 ++
 rtl/mmm_word_sub.sv | 19 +
 rtl/mmm_result_collector.sv | 158 +++++++++++++++
 tb/tb_mmm_result_collector.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Shared types and helpers for the Montgomery multiplier final-reduction stages.
package mmm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DECIDE  = 2'b10,
        ST_DRAIN   = 2'b11
    } state_t;

    localparam int DEF_K = 1024;
    localparam int DEF_W = 16;

    // Bits needed to index 'value' entries; never less than 1.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mmm_word_sub.sv
// Combinational W-bit A - B - bin producing {bout, diff}; chains LSW-first across words.
module mmm_word_sub #(
    parameter int W = 16
)(
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic [W-1:0] o_diff,
    output logic         o_bout
);

    logic [W:0] w_full;

    // A negative result wraps mod 2^(W+1), leaving the borrow in the top bit.
    assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_bin};
    assign o_diff = w_full[W-1:0];
    assign o_bout = w_full[W];

endmodule

// File: rtl/mmm_result_collector.sv
// Collects the final PE's word-serial sum, optionally reduces S-M (MMM_FINAL_SUB_EN), drains LSW-first.
// Last word in -> one DECIDE cycle -> o_out_valid; the PE side has no backpressure, so a word arriving while busy raises o_overrun.
module mmm_result_collector
    import mmm_pkg::*;
#(
    parameter int K = DEF_K,
    parameter int W = DEF_W
)(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_s_in,
    input  logic         i_s_valid,
    input  logic         i_s_top,
    input  logic [W-1:0] i_m_in,
    output logic [W-1:0] o_out_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_busy,
    output logic         o_overrun
);

    localparam int N = K / W;
    localparam int IW = clogb2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic [IW-1:0] w_widx;
    logic          r_busy;
    logic          r_overrun;
    logic          w_acc;
    logic [W-1:0]  w_out_word;
    logic [W-1:0]  r_s_buf [N];

    assign w_acc  = i_s_valid && ((r_state == ST_IDLE) || (r_state == ST_COLLECT));
    assign w_widx = (r_state == ST_IDLE) ? '0 : r_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (i_s_valid) begin
                    w_state_nxt = ST_COLLECT;
                    w_idx_nxt   = IW'(1);
                end
            end
            ST_COLLECT: begin
                if (i_s_valid) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_DECIDE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end
            ST_DECIDE: begin
                w_state_nxt = ST_DRAIN;
                w_idx_nxt   = '0;
            end
            ST_DRAIN: begin
                if (i_out_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_overrun <= r_overrun | (i_s_valid && ((r_state == ST_DECIDE) || (r_state == ST_DRAIN)));
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_acc) begin
            r_s_buf[w_widx] <= i_s_in;
        end
    end

`ifdef MMM_FINAL_SUB_EN
    logic [W-1:0] r_d_buf [N];
    logic         r_borrow;
    logic         r_top;
    logic         r_sel;
    logic         w_bin;
    logic         w_bout;
    logic [W-1:0] w_diff;

    assign w_bin = (r_state == ST_IDLE) ? 1'b0 : r_borrow;

    mmm_word_sub #(.W(W)) u_word_sub (
        .i_a    (i_s_in),
        .i_b    (i_m_in),
        .i_bin  (w_bin),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

    // Carry-out set means S >= 2^K > M, so the difference is taken regardless of the final borrow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_borrow <= 1'b0;
            r_top    <= 1'b0;
            r_sel    <= 1'b0;
        end else begin
            if (w_acc) begin
                r_borrow <= w_bout;
            end
            if (w_acc && (r_state == ST_COLLECT) && (r_idx == LAST_IDX)) begin
                r_top <= i_s_top;
            end
            if (r_state == ST_DECIDE) begin
                r_sel <= r_top | ~r_borrow;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_acc) begin
            r_d_buf[w_widx] <= w_diff;
        end
    end

    assign w_out_word = r_sel ? r_d_buf[r_idx] : r_s_buf[r_idx];
`else
    logic w_unused;

    assign w_unused   = ^{i_m_in, i_s_top};
    assign w_out_word = r_s_buf[r_idx];
`endif

    assign o_out_valid = (r_state == ST_DRAIN);
    assign o_out_data  = (r_state == ST_DRAIN) ? w_out_word : '0;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_mmm_result_collector.sv
// Bench for mmm_result_collector (K=64, W=16): directed and random results against a whole-number model.
module tb_mmm_result_collector;

    localparam int K = 64;
    localparam int W = 16;
    localparam int N = K / W;

`ifdef MMM_FINAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] s_in;
    logic         s_valid;
    logic         s_top;
    logic [W-1:0] m_in;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overrun;

    int n_chk  = 0;
    int n_fail = 0;
    bit exp_ovr = 1'b0;

    always #5 clk = ~clk;

    mmm_result_collector #(.K(K), .W(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_s_in      (s_in),
        .i_s_valid   (s_valid),
        .i_s_top     (s_top),
        .i_m_in      (m_in),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_busy      (busy),
        .o_overrun   (overrun)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-number view: (2^K + S - M) mod 2^K when S_TOP or S >= M, else S.
    function automatic logic [63:0] model(input logic [63:0] s, input logic [63:0] m, input bit top);
        if (SUB_EN && (top || (s >= m))) begin
            return s - m;
        end
        return s;
    endfunction

    task automatic feed(input logic [63:0] s, input logic [63:0] m, input bit top, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    s_top   = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_in    = s[i*W +: W];
            m_in    = m[i*W +: W];
            s_top   = (i == N - 1) ? top : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("busy_collect", busy, 1);
        end
        s_valid = 1'b0;
        s_top   = 1'b0;
        check("valid_in_decide", out_valid, 0);
        @(posedge clk); #1;
        check("valid_first_drain", out_valid, 1);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall word 1 for three cycles.
    task automatic drain(input logic [63:0] res, input int mode, input bit pulse_ovr);
        int idx   = 0;
        int stall = 0;
        int cyc   = 0;
        while (idx < N && cyc < 200) begin
            if (mode == 2 && idx == 1 && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else if (mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            if (pulse_ovr && cyc == 1) begin
                s_valid = 1'b1;
                s_in    = W'($urandom);
                m_in    = W'($urandom);
                exp_ovr = 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, res[idx*W +: W]);
            @(posedge clk); #1;
            if (out_ready) begin
                idx++;
            end
            cyc++;
        end
        if (cyc >= 200) begin
            check("drain_timeout", cyc, 0);
        end
        out_ready = 1'b0;
        s_valid   = 1'b0;
        check("valid_after_drain", out_valid, 0);
        check("busy_after_drain", busy, 0);
        check("overrun_flag", overrun, exp_ovr);
    endtask

    task automatic run_case(input logic [63:0] s, input logic [63:0] m, input bit top,
                            input bit gaps, input int mode, input bit pulse_ovr);
        feed(s, m, top, gaps);
        drain(model(s, m, top), mode, pulse_ovr);
    endtask

    initial begin
        logic [63:0] rs;
        logic [63:0] rm;
        rst_n     = 1'b0;
        s_in      = '0;
        m_in      = '0;
        s_valid   = 1'b0;
        s_top     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_case(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0, 1'b0, 0, 1'b0);
        run_case(64'h1234_5678_9ABC_DEF1, 64'h1234_5678_9ABC_DEF1, 1'b0, 1'b0, 0, 1'b0);
        run_case(64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0, 0, 1'b0);
        run_case(64'h0000_0000_0000_0009, 64'h0000_0000_0000_0007, 1'b0, 1'b1, 0, 1'b0);
        run_case(64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 2, 1'b0);

        // Reset part-way through collection.
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_in    = W'($urandom);
            m_in    = W'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("busy_async_rst", busy, 0);
        check("valid_async_rst", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_case(64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);

        run_case(64'h0F0F_F0F0_1234_8765, 64'h0F0F_F0F0_1234_8764, 1'b0, 1'b0, 0, 1'b1);

        for (int t = 0; t < 20; t++) begin
            rs = {$urandom, $urandom};
            rm = (t % 5 == 0) ? rs : {$urandom, $urandom};
            run_case(rs, rm, 1'($urandom_range(0, 1)), 1'b1, 1, 1'($urandom_range(0, 1)));
        end

        rst_n = 1'b0;
        #3;
        exp_ovr = 1'b0;
        check("overrun_cleared", overrun, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
